player_move_sequencer: RTL and testbench

Sequences every player move into the shared 15x20 tile map (one 60-bit word per row, 3 bits per tile). It accepts direction requests from the board switches and arbitrates between simultaneous presses. It checks bounds and walls, then performs the map read-modify-write cycles. All map accesses are confined to VGA blanking, so the VGA scan never sees a half-written row. The block sits between the switch inputs and the map storage owner, and exports the player position and a move count for the 7-segment display.

---
 rtl/player_move_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_player_move_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : player_move_sequencer
// Description : Arbitrates direction requests, checks bounds and walls, and
//               performs blanking-confined read-modify-write cycles on the
//               15x20 tile map to move the player tile.
// Revision    : 1.0 - initial release
// ============================================================================
module player_move_sequencer #(
    parameter int         MAP_COLS    = 20,
    parameter int         MAP_ROWS    = 15,
    parameter int         START_X     = 15,
    parameter int         START_Y     = 10,
    parameter logic [2:0] START_UNDER = 3'b000,
    parameter logic [2:0] TILE_PLAYER = 3'b010,
    parameter logic [2:0] TILE_WALL   = 3'b011,
    parameter int         MOVE_PERIOD = 25000000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Up,
    input  logic        i_Down,
    input  logic        i_Left,
    input  logic        i_Right,
    input  logic        i_VBlank,
    output logic        o_Rd_Req,
    output logic [3:0]  o_Rd_Row,
    input  logic [59:0] i_Rd_Data,
    output logic        o_Wr_En,
    output logic [3:0]  o_Wr_Row,
    output logic [59:0] o_Wr_Data,
    output logic [4:0]  o_Player_X,
    output logic [3:0]  o_Player_Y,
    output logic        o_Busy,
    output logic        o_Blocked,
    output logic [6:0]  o_Move_Count
);

    localparam int              CNT_W    = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(MOVE_PERIOD - 1);
    localparam logic [4:0]      C_LAST_X = 5'(MAP_COLS - 1);
    localparam logic [3:0]      C_LAST_Y = 4'(MAP_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_DST = 3'd1,
        S_CHK    = 3'd2,
        S_WR_DST = 3'd3,
        S_RD_SRC = 3'd4,
        S_WR_SRC = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           r_state, w_state;
    logic [4:0]       r_x, w_x, r_tx, w_tx;
    logic [3:0]       r_y, w_y, r_ty, w_ty;
    logic             r_vert, w_vert;
    logic [2:0]       r_under, w_under, r_new_under, w_new_under;
    logic [59:0]      r_row, w_row;
    logic             r_rd_pend, w_rd_pend;
    logic [CNT_W-1:0] r_cool, w_cool;
    logic [6:0]       r_count, w_count;

    logic [2:0]       w_tile;
    logic [59:0]      w_dst_data;
    logic [59:0]      w_src_row;

    // Extract the 3-bit tile of one column from a row word
    function automatic logic [2:0] get_tile(input logic [59:0] row, input logic [4:0] col);
        logic [59:0] shifted;
        shifted = row >> ({1'b0, col} * 6'd3);
        return shifted[2:0];
    endfunction

    // Replace the 3-bit tile of one column inside a row word
    function automatic logic [59:0] set_tile(input logic [59:0] row, input logic [4:0] col,
                                             input logic [2:0] tile);
        logic [5:0] sh;
        sh = {1'b0, col} * 6'd3;
        return (row & ~(60'h7 << sh)) | ({57'd0, tile} << sh);
    endfunction

    assign o_Busy       = (r_state != S_IDLE);
    assign o_Player_X   = r_x;
    assign o_Player_Y   = r_y;
    assign o_Move_Count = r_count;

    // Next-state, datapath and strobe decode for the move sequence
    always_comb begin
        w_state     = r_state;
        w_x         = r_x;
        w_y         = r_y;
        w_tx        = r_tx;
        w_ty        = r_ty;
        w_vert      = r_vert;
        w_under     = r_under;
        w_new_under = r_new_under;
        w_row       = r_row;
        w_rd_pend   = r_rd_pend;
        w_cool      = r_cool;
        w_count     = r_count;
        o_Rd_Req    = 1'b0;
        o_Rd_Row    = 4'd0;
        o_Wr_En     = 1'b0;
        o_Wr_Row    = 4'd0;
        o_Wr_Data   = 60'd0;
        o_Blocked   = 1'b0;
        w_tile      = get_tile(i_Rd_Data, r_tx);
        // Destination row: player placed; a horizontal move also restores the old field
        w_dst_data  = set_tile(r_row, r_tx, TILE_PLAYER);
        if (!r_vert) begin
            w_dst_data = set_tile(w_dst_data, r_x, r_under);
        end
        // Source-row data is only on the bus the cycle after its read
        w_src_row   = r_rd_pend ? i_Rd_Data : r_row;

        case (r_state)
            S_IDLE: begin
                if (r_cool != '0) begin
                    w_cool = r_cool - CNT_W'(1);
                end else if (i_Up || i_Down || i_Left || i_Right) begin
                    w_tx   = r_x;
                    w_ty   = r_y;
                    w_vert = i_Up || i_Down;
                    if (i_Up) begin
                        w_ty = r_y - 4'd1;
                    end else if (i_Down) begin
                        w_ty = r_y + 4'd1;
                    end else if (i_Left) begin
                        w_tx = r_x - 5'd1;
                    end else begin
                        w_tx = r_x + 5'd1;
                    end
                    if ((i_Up && r_y == 4'd0) ||
                        (!i_Up && i_Down && r_y == C_LAST_Y) ||
                        (!i_Up && !i_Down && i_Left && r_x == 5'd0) ||
                        (!i_Up && !i_Down && !i_Left && r_x == C_LAST_X)) begin
                        o_Blocked = 1'b1;
                        w_cool    = C_RELOAD;
                    end else begin
                        w_state = S_RD_DST;
                    end
                end
            end
            S_RD_DST: begin
                if (i_VBlank) begin
                    o_Rd_Req = 1'b1;
                    o_Rd_Row = r_ty;
                    w_state  = S_CHK;
                end
            end
            S_CHK: begin
                if (w_tile == TILE_WALL) begin
                    o_Blocked = 1'b1;
                    w_cool    = C_RELOAD;
                    w_state   = S_IDLE;
                end else begin
                    w_row       = i_Rd_Data;
                    w_new_under = w_tile;
                    w_state     = S_WR_DST;
                end
            end
            S_WR_DST: begin
                if (i_VBlank) begin
                    o_Wr_En   = 1'b1;
                    o_Wr_Row  = r_ty;
                    o_Wr_Data = w_dst_data;
                    w_state   = r_vert ? S_RD_SRC : S_DONE;
                end
            end
            S_RD_SRC: begin
                if (i_VBlank) begin
                    o_Rd_Req  = 1'b1;
                    o_Rd_Row  = r_y;
                    w_rd_pend = 1'b1;
                    w_state   = S_WR_SRC;
                end
            end
            S_WR_SRC: begin
                w_row     = w_src_row;
                w_rd_pend = 1'b0;
                if (i_VBlank) begin
                    o_Wr_En   = 1'b1;
                    o_Wr_Row  = r_y;
                    o_Wr_Data = set_tile(w_src_row, r_x, r_under);
                    w_state   = S_DONE;
                end
            end
            S_DONE: begin
                w_x     = r_tx;
                w_y     = r_ty;
                w_under = r_new_under;
                w_count = (r_count == 7'd99) ? 7'd0 : r_count + 7'd1;
                w_cool  = C_RELOAD;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Reset aborts immediately: no strobe or pulse escapes on the reset edge
        if (i_Reset) begin
            o_Rd_Req  = 1'b0;
            o_Rd_Row  = 4'd0;
            o_Wr_En   = 1'b0;
            o_Wr_Row  = 4'd0;
            o_Wr_Data = 60'd0;
            o_Blocked = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_x         <= 5'(START_X);
            r_y         <= 4'(START_Y);
            r_tx        <= 5'(START_X);
            r_ty        <= 4'(START_Y);
            r_vert      <= 1'b0;
            r_under     <= START_UNDER;
            r_new_under <= START_UNDER;
            r_row       <= 60'd0;
            r_rd_pend   <= 1'b0;
            r_cool      <= '0;
            r_count     <= 7'd0;
        end else begin
            r_state     <= w_state;
            r_x         <= w_x;
            r_y         <= w_y;
            r_tx        <= w_tx;
            r_ty        <= w_ty;
            r_vert      <= w_vert;
            r_under     <= w_under;
            r_new_under <= w_new_under;
            r_row       <= w_row;
            r_rd_pend   <= w_rd_pend;
            r_cool      <= w_cool;
            r_count     <= w_count;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_player_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_move_sequencer
// Description : Self-checking bench with a tile-map reference model for
//               player_move_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_move_sequencer;

    localparam int         MP     = 4;
    localparam logic [2:0] PLAYER = 3'b010;
    localparam logic [2:0] WALL   = 3'b011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        vb_man = 1'b1, vb_rnd = 1'b1, vb_rand = 1'b0;
    logic        vblank;
    logic        rd_req, wr_en, busy, blocked;
    logic [3:0]  rd_row, wr_row, py;
    logic [4:0]  px;
    logic [6:0]  mcount;
    logic [59:0] rd_data = 60'd0;
    logic [59:0] wr_data;

    assign vblank = vb_rand ? vb_rnd : vb_man;

    player_move_sequencer #(.MOVE_PERIOD(MP)) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_Up(btn_up), .i_Down(btn_down), .i_Left(btn_left), .i_Right(btn_right),
        .i_VBlank(vblank),
        .o_Rd_Req(rd_req), .o_Rd_Row(rd_row), .i_Rd_Data(rd_data),
        .o_Wr_En(wr_en), .o_Wr_Row(wr_row), .o_Wr_Data(wr_data),
        .o_Player_X(px), .o_Player_Y(py), .o_Busy(busy), .o_Blocked(blocked),
        .o_Move_Count(mcount)
    );

    always #5 clk = ~clk;

    // Map owner: row storage, one-cycle read latency, backdoor reload
    logic [59:0] mem [15];
    logic [59:0] init_map [15];
    int load_req = 0, load_ack = 0;
    always @(posedge clk) begin
        if (load_req != load_ack) begin
            for (int r = 0; r < 15; r++) mem[r] = init_map[r];
            load_ack = load_req;
        end else if (wr_en && wr_row < 4'd15) begin
            mem[wr_row] = wr_data;
        end
        if (rd_req && rd_row < 4'd15) rd_data <= mem[rd_row];
    end

    // Strobe and pulse bookkeeping
    int n_rd = 0, n_wr = 0, n_blk = 0, n_viol = 0;
    always @(negedge clk) begin
        if (rd_req) n_rd++;
        if (wr_en) n_wr++;
        if (blocked) n_blk++;
        if ((rd_req || wr_en) && !vblank) n_viol++;
        if (rd_req && wr_en) n_viol++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        vb_rnd = ($urandom_range(0, 2) != 0);
    end

    // Reference model: tile grid plus player bookkeeping
    logic [2:0] emap [15][20];
    int ex, ey, ecount;
    logic [2:0] eunder;
    int errors = 0, checks = 0;

    function automatic logic [59:0] pack_row(input int r);
        logic [59:0] w;
        w = 60'd0;
        for (int c = 0; c < 20; c++) w[3*c +: 3] = emap[r][c];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_map();
        for (int r = 0; r < 15; r++) init_map[r] = pack_row(r);
        load_req++;
        step();
        step();
    endtask

    task automatic do_reset();
        vb_rand = 1'b0;
        vb_man  = 1'b1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        rst = 1'b1;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++) emap[r][c] = 3'b000;
        emap[10][15] = PLAYER;
        ex = 15; ey = 10; eunder = 3'b000; ecount = 0;
        for (int r = 0; r < 15; r++) init_map[r] = pack_row(r);
        load_req++;
        step();
        step();
        rst = 1'b0;
    endtask

    // kind: 0 out of bounds, 1 wall, 2 horizontal move, 3 vertical move
    task automatic model_move(input logic [3:0] req, output int kind);
        int tx, ty;
        bit vert;
        logic [2:0] t;
        tx = ex; ty = ey; vert = 0;
        if (req[3]) begin ty = ey - 1; vert = 1; end
        else if (req[2]) begin ty = ey + 1; vert = 1; end
        else if (req[1]) tx = ex - 1;
        else tx = ex + 1;
        if (tx < 0 || tx >= 20 || ty < 0 || ty >= 15) kind = 0;
        else if (emap[ty][tx] == WALL) kind = 1;
        else begin
            t = emap[ty][tx];
            emap[ty][tx] = PLAYER;
            emap[ey][ex] = eunder;
            eunder = t;
            ex = tx; ey = ty;
            ecount = (ecount + 1) % 100;
            kind = vert ? 3 : 2;
        end
    endtask

    task automatic run_move(input logic [3:0] req, input string tag);
        int k, rd0, wr0, bl0, cyc, exp_rd, exp_wr, exp_bl;
        bit seen_busy, fin;
        model_move(req, k);
        rd0 = n_rd; wr0 = n_wr; bl0 = n_blk;
        {btn_up, btn_down, btn_left, btn_right} = req;
        fin = 0; seen_busy = 0; cyc = 0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (blocked) fin = 1;
            else if (busy) seen_busy = 1;
            else if (seen_busy) fin = 1;
        end
        step();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        repeat (MP + 1) step();
        exp_rd = (k == 0) ? 0 : ((k == 3) ? 2 : 1);
        exp_wr = (k < 2) ? 0 : ((k == 3) ? 2 : 1);
        exp_bl = (k < 2) ? 1 : 0;
        checks++;
        if (!fin) begin errors++; $display("FAIL %s done: got no completion, want completion in 200 cycles", tag); end
        checks++;
        if (n_rd - rd0 !== exp_rd) begin errors++; $display("FAIL %s reads: got %0d want %0d", tag, n_rd - rd0, exp_rd); end
        checks++;
        if (n_wr - wr0 !== exp_wr) begin errors++; $display("FAIL %s writes: got %0d want %0d", tag, n_wr - wr0, exp_wr); end
        checks++;
        if (n_blk - bl0 !== exp_bl) begin errors++; $display("FAIL %s blocked: got %0d want %0d", tag, n_blk - bl0, exp_bl); end
        checks++;
        if (int'(px) !== ex || int'(py) !== ey) begin
            errors++; $display("FAIL %s pos: got (%0d,%0d) want (%0d,%0d)", tag, px, py, ex, ey);
        end
        checks++;
        if (int'(mcount) !== ecount) begin errors++; $display("FAIL %s count: got %0d want %0d", tag, mcount, ecount); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s idle: got busy=%b want 0", tag, busy); end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({rd_req, wr_en, busy, blocked} !== 4'b0) begin
            errors++; $display("FAIL reset strobes: got %b want 0000", {rd_req, wr_en, busy, blocked});
        end
        checks++;
        if (rd_row !== 4'd0 || wr_row !== 4'd0 || wr_data !== 60'd0) begin
            errors++; $display("FAIL reset rows: got rd=%0d wr=%0d data=%h want 0", rd_row, wr_row, wr_data);
        end
        checks++;
        if (px !== 5'd15 || py !== 4'd10) begin errors++; $display("FAIL reset pos: got (%0d,%0d) want (15,10)", px, py); end
        checks++;
        if (mcount !== 7'd0) begin errors++; $display("FAIL reset count: got %0d want 0", mcount); end
        step();
    endtask

    task automatic test_right_move();
        logic [59:0] row;
        do_reset();
        run_move(4'b0001, "right");
        row = mem[10];
        checks++;
        if (row[50:48] !== PLAYER || row[47:45] !== 3'b000) begin
            errors++; $display("FAIL right fields: got %b/%b want 010/000", row[50:48], row[47:45]);
        end
        checks++;
        if (row !== pack_row(10)) begin errors++; $display("FAIL right row: got %h want %h", row, pack_row(10)); end
    endtask

    task automatic test_bounds();
        do_reset();
        for (int i = 0; i < 10; i++) run_move(4'b1000, "climb");
        run_move(4'b1000, "top_edge");
        run_move(4'b0001, "right_ok");
        for (int i = 0; i < 4; i++) run_move(4'b0001, "to_right");
        run_move(4'b0001, "right_edge");
    endtask

    task automatic test_wall();
        do_reset();
        emap[10][14] = WALL;
        sync_map();
        run_move(4'b0010, "wall");
        checks++;
        if (mem[10] !== pack_row(10)) begin errors++; $display("FAIL wall row: got %h want %h", mem[10], pack_row(10)); end
    endtask

    task automatic test_vblank_gap();
        int k, nrd, cyc, gap_bad;
        bit fin;
        do_reset();
        model_move(4'b1000, k);
        btn_up = 1'b1;
        nrd = 0; cyc = 0;
        while (nrd < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rd_req) nrd++;
        end
        checks++;
        if (nrd != 2) begin errors++; $display("FAIL gap reads: got %0d want 2", nrd); end
        step();
        vb_man = 1'b0;
        btn_up = 1'b0;
        gap_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || busy !== 1'b1) gap_bad++;
        end
        checks++;
        if (gap_bad != 0) begin errors++; $display("FAIL gap hold: got %0d bad cycles want 0", gap_bad); end
        step();
        vb_man = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_row !== 4'd10 || wr_data !== pack_row(10)) begin
            errors++; $display("FAIL gap restore: got en=%b row=%0d data=%h want 1/10/%h", wr_en, wr_row, wr_data, pack_row(10));
        end
        fin = 0; cyc = 0;
        while (!fin && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (!busy) fin = 1;
        end
        repeat (MP + 1) step();
        checks++;
        if (px !== 5'd15 || py !== 4'd9 || mcount !== 7'd1) begin
            errors++; $display("FAIL gap pos: got (%0d,%0d) n=%0d want (15,9) n=1", px, py, mcount);
        end
        checks++;
        if (mem[9] !== pack_row(9) || mem[10] !== pack_row(10)) begin
            errors++; $display("FAIL gap map: got %h %h want %h %h", mem[9], mem[10], pack_row(9), pack_row(10));
        end
    endtask

    task automatic test_priority();
        int k, cyc, low;
        bit fin;
        do_reset();
        for (int i = 0; i < 10; i++) run_move(4'b0010, "to_x5");
        for (int i = 0; i < 5; i++) run_move(4'b1000, "to_y5");
        model_move(4'b1010, k);
        {btn_up, btn_left} = 2'b11;
        fin = 0; cyc = 0;
        while (!fin && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) fin = 1;
        end
        while (fin && busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (int'(px) !== ex || int'(py) !== ey) begin
            errors++; $display("FAIL prio pos: got (%0d,%0d) want (%0d,%0d)", px, py, ex, ey);
        end
        low = 0;
        while (!busy && low < 50) begin
            low++;
            @(negedge clk);
        end
        checks++;
        if (low < MP || low >= 50) begin errors++; $display("FAIL prio cooldown: got %0d idle cycles want >= %0d", low, MP); end
        model_move(4'b1010, k);
        fin = 0; cyc = 0;
        while (!fin && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!busy) fin = 1;
        end
        step();
        {btn_up, btn_left} = 2'b00;
        repeat (MP + 1) step();
        checks++;
        if (int'(px) !== ex || int'(py) !== ey || int'(mcount) !== ecount) begin
            errors++; $display("FAIL prio repeat: got (%0d,%0d) n=%0d want (%0d,%0d) n=%0d", px, py, mcount, ex, ey, ecount);
        end
    endtask

    task automatic test_wrap_reset();
        int cyc;
        do_reset();
        for (int i = 0; i < 100; i++) run_move((i % 2 == 0) ? 4'b0010 : 4'b0001, "wrap");
        checks++;
        if (mcount !== 7'd0) begin errors++; $display("FAIL wrap count: got %0d want 0", mcount); end
        btn_up = 1'b1;
        cyc = 0;
        while (!rd_req && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        step();
        vb_man = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall wr: got en=%b busy=%b want 0/1", wr_en, busy); end
        rst = 1'b1;
        btn_up = 1'b0;
        vb_man = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL reset gate: got wr=%b rd=%b want 0/0", wr_en, rd_req); end
        step();
        checks++;
        if (busy !== 1'b0 || px !== 5'd15 || py !== 4'd10 || mcount !== 7'd0 || wr_en !== 1'b0 || rd_req !== 1'b0) begin
            errors++; $display("FAIL abort: got busy=%b (%0d,%0d) n=%0d wr=%b rd=%b want 0 (15,10) 0 0 0",
                               busy, px, py, mcount, wr_en, rd_req);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++)
                if (!(r == 10 && c == 15) && $urandom_range(0, 7) == 0) emap[r][c] = WALL;
        sync_map();
        vb_rand = 1'b1;
        for (int i = 0; i < 40; i++) run_move(4'($urandom_range(1, 15)), "random");
        vb_rand = 1'b0;
        for (int r = 0; r < 15; r++) begin
            checks++;
            if (mem[r] !== pack_row(r)) begin errors++; $display("FAIL random row %0d: got %h want %h", r, mem[r], pack_row(r)); end
        end
        checks++;
        if (n_viol != 0) begin errors++; $display("FAIL strobe rules: got %0d violations want 0", n_viol); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_right_move();
        test_bounds();
        test_wall();
        test_vblank_gap();
        test_priority();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
